dmem_resp: RTL and testbench

//  Data-memory responder: the far end of the core's D-Mem port (MemRead/MemWrite/aluout/WriteData/ReadData).

---
 rtl/dmem_pkg.sv | 22 ++
 rtl/dmem_lane.sv | 89 ++++++++
 rtl/dmem_resp.sv | 128 ++++++++++++
 tb/tb_dmem_resp.sv | 200 ++++++++++++++++++++
 4 files changed

// File: rtl/dmem_pkg.sv
// rtl/dmem_pkg.sv - data-memory responder encodings and defaults
package dmem_pkg;

    localparam int DMEM_DEPTH = 128;

    typedef enum logic [2:0] {
        LD_NONE = 3'b000,
        LD_B    = 3'b001,
        LD_H    = 3'b010,
        LD_W    = 3'b011,
        LD_BU   = 3'b100,
        LD_HU   = 3'b101
    } ld_e;

    typedef enum logic [1:0] {
        ST_NONE = 2'b00,
        ST_B    = 2'b01,
        ST_H    = 2'b10,
        ST_W    = 2'b11
    } st_e;

endpackage

// File: rtl/dmem_lane.sv
// rtl/dmem_lane.sv - byte-lane steering, load extension and alignment checks
module dmem_lane
    import dmem_pkg::*;
(
    input  logic [2:0]  ld_type,
    input  logic [1:0]  st_type,
    input  logic [1:0]  addr_lo,
    input  logic [31:0] wdata,
    input  logic [31:0] rword,
    output logic        ld_valid,
    output logic        ld_mis,
    output logic [31:0] ld_data,
    output logic        st_valid,
    output logic        st_mis,
    output logic [3:0]  be,
    output logic [31:0] st_data
);

    logic [31:0] rshift;
    logic [7:0]  byte_v;
    logic [15:0] half_v;

    always_comb begin
        rshift = rword >> {addr_lo, 3'b000};
        byte_v = rshift[7:0];
        half_v = addr_lo[1] ? rword[31:16] : rword[15:0];
    end

    always_comb begin
        ld_valid = 1'b0;
        ld_mis   = 1'b0;
        ld_data  = '0;
        case (ld_type)
            LD_B: begin
                ld_valid = 1'b1;
                ld_data  = {{24{byte_v[7]}}, byte_v};
            end
            LD_BU: begin
                ld_valid = 1'b1;
                ld_data  = {24'h0, byte_v};
            end
            LD_H: begin
                ld_valid = 1'b1;
                ld_mis   = addr_lo[0];
                ld_data  = {{16{half_v[15]}}, half_v};
            end
            LD_HU: begin
                ld_valid = 1'b1;
                ld_mis   = addr_lo[0];
                ld_data  = {16'h0, half_v};
            end
            LD_W: begin
                ld_valid = 1'b1;
                ld_mis   = |addr_lo;
                ld_data  = rword;
            end
            default: ;
        endcase
    end

    // Store data is replicated across lanes; the byte enable picks which ones land.
    always_comb begin
        st_valid = 1'b0;
        st_mis   = 1'b0;
        be       = 4'b0000;
        st_data  = '0;
        case (st_type)
            ST_B: begin
                st_valid = 1'b1;
                be       = 4'b0001 << addr_lo;
                st_data  = {4{wdata[7:0]}};
            end
            ST_H: begin
                st_valid = 1'b1;
                st_mis   = addr_lo[0];
                be       = addr_lo[1] ? 4'b1100 : 4'b0011;
                st_data  = {2{wdata[15:0]}};
            end
            ST_W: begin
                st_valid = 1'b1;
                st_mis   = |addr_lo;
                be       = 4'b1111;
                st_data  = wdata;
            end
            default: ;
        endcase
    end

endmodule

// File: rtl/dmem_resp.sv
// rtl/dmem_resp.sv - flop-based data memory with error flags, counters and debug port
module dmem_resp
    import dmem_pkg::*;
#(
    parameter int DEPTH = DMEM_DEPTH,
    parameter int AW    = $clog2(DEPTH)
) (
    input  logic          clk,
    input  logic          rst,
    input  logic [2:0]    MemRead,
    input  logic [1:0]    MemWrite,
    input  logic [31:0]   addr,
    input  logic [31:0]   WriteData,
    output logic [31:0]   ReadData,
    input  logic          err_clr,
    output logic          err_mis,
    output logic          err_oob,
    output logic          err_rw,
    input  logic [AW-1:0] dbg_addr,
    output logic [31:0]   dbg_data,
    output logic [31:0]   n_load,
    output logic [31:0]   n_store
);

    localparam logic [31:0] DEPTH_U = DEPTH;

    logic [31:0] mem_q [DEPTH];
    logic [31:0] mem_d [DEPTH];
    logic        err_mis_q, err_mis_d;
    logic        err_oob_q, err_oob_d;
    logic        err_rw_q,  err_rw_d;
    logic [31:0] n_load_q,  n_load_d;
    logic [31:0] n_store_q, n_store_d;

    logic [AW-1:0] widx;
    logic          oob;
    logic [31:0]   rword;
    logic          ld_valid, ld_mis, st_valid, st_mis;
    logic [31:0]   ld_data, st_data;
    logic [3:0]    be;
    logic          ld_acc, st_acc;

    always_comb begin
        widx  = addr[AW+1:2];
        oob   = {2'b00, addr[31:2]} >= DEPTH_U;
        rword = oob ? '0 : mem_q[widx];
    end

    dmem_lane u_lane (
        .ld_type  (MemRead),
        .st_type  (MemWrite),
        .addr_lo  (addr[1:0]),
        .wdata    (WriteData),
        .rword    (rword),
        .ld_valid (ld_valid),
        .ld_mis   (ld_mis),
        .ld_data  (ld_data),
        .st_valid (st_valid),
        .st_mis   (st_mis),
        .be       (be),
        .st_data  (st_data)
    );

    always_comb begin
        ld_acc   = ld_valid & ~ld_mis & ~oob;
        st_acc   = st_valid & ~st_mis & ~oob;
        ReadData = ld_acc ? ld_data : '0;
        dbg_data = mem_q[dbg_addr];
    end

    always_comb begin
        mem_d = mem_q;
        if (st_acc) begin
            for (int b = 0; b < 4; b++) begin
                if (be[b]) begin
                    mem_d[widx][8*b +: 8] = st_data[8*b +: 8];
                end
            end
        end
    end

    // A fresh error in the clear cycle must win, so set terms are applied after the clear.
    always_comb begin
        err_mis_d = err_clr ? 1'b0 : err_mis_q;
        err_oob_d = err_clr ? 1'b0 : err_oob_q;
        err_rw_d  = err_clr ? 1'b0 : err_rw_q;
        if ((ld_valid & ld_mis) | (st_valid & st_mis)) begin
            err_mis_d = 1'b1;
        end
        if ((ld_valid | st_valid) & oob) begin
            err_oob_d = 1'b1;
        end
        if ((|MemRead) & (|MemWrite)) begin
            err_rw_d = 1'b1;
        end
        n_load_d  = n_load_q  + {31'h0, ld_acc};
        n_store_d = n_store_q + {31'h0, st_acc};
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem_q[i] <= '0;
            end
            err_mis_q <= 1'b0;
            err_oob_q <= 1'b0;
            err_rw_q  <= 1'b0;
            n_load_q  <= '0;
            n_store_q <= '0;
        end else begin
            mem_q     <= mem_d;
            err_mis_q <= err_mis_d;
            err_oob_q <= err_oob_d;
            err_rw_q  <= err_rw_d;
            n_load_q  <= n_load_d;
            n_store_q <= n_store_d;
        end
    end

    always_comb begin
        err_mis = err_mis_q;
        err_oob = err_oob_q;
        err_rw  = err_rw_q;
        n_load  = n_load_q;
        n_store = n_store_q;
    end

endmodule

// File: tb/tb_dmem_resp.sv
// tb/tb_dmem_resp.sv - directed self-checking bench for dmem_resp
module tb_dmem_resp;

    logic        clk;
    logic        rst;
    logic [2:0]  MemRead;
    logic [1:0]  MemWrite;
    logic [31:0] addr;
    logic [31:0] WriteData;
    logic [31:0] ReadData;
    logic        err_clr;
    logic        err_mis;
    logic        err_oob;
    logic        err_rw;
    logic [6:0]  dbg_addr;
    logic [31:0] dbg_data;
    logic [31:0] n_load;
    logic [31:0] n_store;

    int total;
    int bad;

    dmem_resp dut (
        .clk       (clk),
        .rst       (rst),
        .MemRead   (MemRead),
        .MemWrite  (MemWrite),
        .addr      (addr),
        .WriteData (WriteData),
        .ReadData  (ReadData),
        .err_clr   (err_clr),
        .err_mis   (err_mis),
        .err_oob   (err_oob),
        .err_rw    (err_rw),
        .dbg_addr  (dbg_addr),
        .dbg_data  (dbg_data),
        .n_load    (n_load),
        .n_store   (n_store)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
        total++;
        assert (obs === exp_v) else begin
            bad++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp_v);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic dbg_word(input string tag, input logic [6:0] idx, input logic [31:0] exp_v);
        dbg_addr = idx;
        #1;
        chk(tag, dbg_data, exp_v);
    endtask

    initial begin
        total     = 0;
        bad       = 0;
        rst       = 1'b1;
        MemRead   = 3'b000;
        MemWrite  = 2'b00;
        addr      = '0;
        WriteData = '0;
        err_clr   = 1'b0;
        dbg_addr  = '0;
        #12;
        rst = 1'b0;
        tick();

        // 1: reset contents
        for (int i = 0; i < 128; i++) begin
            dbg_word("reset_word", 7'(i), 32'h0);
        end
        chk("reset_err_mis", {31'h0, err_mis}, 32'h0);
        chk("reset_err_oob", {31'h0, err_oob}, 32'h0);
        chk("reset_err_rw", {31'h0, err_rw}, 32'h0);
        chk("reset_n_load", n_load, 32'h0);
        chk("reset_n_store", n_store, 32'h0);
        tick();
        MemRead = 3'b011; addr = 32'h0;
        #1;
        chk("reset_lw0", ReadData, 32'h0);
        MemRead = 3'b000;

        // 2: extension
        tick();
        MemWrite = 2'b11; addr = 32'h10; WriteData = 32'h8000_00F0;
        tick();
        MemWrite = 2'b00; MemRead = 3'b001;
        #1; chk("lb_10", ReadData, 32'hFFFF_FFF0);
        tick();
        MemRead = 3'b100;
        #1; chk("lbu_10", ReadData, 32'h0000_00F0);
        tick();
        MemRead = 3'b010; addr = 32'h12;
        #1; chk("lh_12", ReadData, 32'hFFFF_8000);
        tick();
        MemRead = 3'b101;
        #1; chk("lhu_12", ReadData, 32'h0000_8000);
        tick();
        MemRead = 3'b000;
        #1;
        chk("cnt_store_2", n_store, 32'd1);
        chk("cnt_load_2", n_load, 32'd4);

        // 3: byte-lane merging
        MemWrite = 2'b11; addr = 32'h20; WriteData = 32'h0;
        tick();
        MemWrite = 2'b01; addr = 32'h23; WriteData = 32'hFFFF_FFAB;
        tick();
        MemWrite = 2'b10; addr = 32'h20; WriteData = 32'hCDEF_1234;
        tick();
        MemWrite = 2'b00;
        dbg_word("merge_20", 7'd8, 32'hAB00_1234);
        chk("cnt_store_3", n_store, 32'd4);

        // 4: misaligned store, clear, clear-vs-set
        MemWrite = 2'b11; addr = 32'h21; WriteData = 32'hDEAD_BEEF;
        tick();
        MemWrite = 2'b00;
        dbg_word("mis_word", 7'd8, 32'hAB00_1234);
        chk("mis_flag", {31'h0, err_mis}, 32'h1);
        chk("mis_n_store", n_store, 32'd4);
        chk("mis_no_oob", {31'h0, err_oob}, 32'h0);
        err_clr = 1'b1;
        tick();
        err_clr = 1'b0;
        #1; chk("mis_cleared", {31'h0, err_mis}, 32'h0);
        err_clr = 1'b1; MemWrite = 2'b10; addr = 32'h21;
        tick();
        err_clr = 1'b0; MemWrite = 2'b00;
        #1; chk("clr_vs_set", {31'h0, err_mis}, 32'h1);
        dbg_word("mis_sh_word", 7'd8, 32'hAB00_1234);
        err_clr = 1'b1;
        tick();
        err_clr = 1'b0;

        // 5: out of range
        MemRead = 3'b011; addr = 32'h200;
        #1; chk("oob_lw_data", ReadData, 32'h0);
        tick();
        MemRead = 3'b000;
        #1;
        chk("oob_flag", {31'h0, err_oob}, 32'h1);
        chk("oob_n_load", n_load, 32'd4);
        MemWrite = 2'b11; WriteData = 32'h1234_5678;
        tick();
        MemWrite = 2'b00;
        dbg_word("oob_alias0", 7'd0, 32'h0);
        dbg_word("oob_last", 7'd127, 32'h0);
        chk("oob_n_store", n_store, 32'd4);
        err_clr = 1'b1;
        tick();
        err_clr = 1'b0;
        MemRead = 3'b011; addr = 32'h202;
        tick();
        MemRead = 3'b000;
        #1;
        chk("both_mis", {31'h0, err_mis}, 32'h1);
        chk("both_oob", {31'h0, err_oob}, 32'h1);

        // 6: read-before-write, then async reset
        MemWrite = 2'b11; addr = 32'h8; WriteData = 32'h1111_2222;
        tick();
        MemRead = 3'b011; WriteData = 32'h55;
        #1; chk("rbw_old", ReadData, 32'h1111_2222);
        tick();
        MemWrite = 2'b00;
        #1;
        chk("rbw_new", ReadData, 32'h0000_0055);
        chk("rw_flag", {31'h0, err_rw}, 32'h1);
        chk("rw_n_load", n_load, 32'd5);
        chk("rw_n_store", n_store, 32'd6);
        MemWrite = 2'b11; WriteData = 32'h99;
        rst = 1'b1;
        #1;
        dbg_word("rst_word2", 7'd2, 32'h0);
        chk("rst_n_load", n_load, 32'h0);
        chk("rst_n_store", n_store, 32'h0);
        chk("rst_err_rw", {31'h0, err_rw}, 32'h0);
        chk("rst_readdata", ReadData, 32'h0);
        tick();
        rst = 1'b0; MemWrite = 2'b00; MemRead = 3'b000;
        dbg_word("rst_store_dropped", 7'd2, 32'h0);
        dbg_word("rst_word8", 7'd8, 32'h0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
